zfsoc_led_sequencer: RTL

//  Avalon-MM slave that sequences the board LED bank in hardware, so the CPU no

---
 rtl/zfsoc_led_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/zfsoc_led_sequencer.sv
// ---------------------------------------------------------------------------
// zfsoc_led_sequencer
// Avalon-MM slave that sequences the board LED bank in hardware. Four modes
// (off, static, blink, chase), each gated by a 16-step PWM brightness stage.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register select: 0 CTRL, 1 PATTERN, 2 PERIOD, 3 DUTY/STEP
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational, zero-extended
//   out_port    LED drive, registered
// ---------------------------------------------------------------------------
module zfsoc_led_sequencer #(
   parameter int unsigned N_LEDS     = 6,
   parameter int unsigned PERIOD_W   = 24,
   parameter int unsigned PERIOD_RST = 12500000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [N_LEDS-1:0]   out_port
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DUTY_W   = 5;
   localparam int unsigned PWM_W    = 4;
   localparam int unsigned STEP_LSB = 8;

   // Mode FSM states; the state register is CTRL itself
   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STATIC = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;
   localparam logic [1:0] MODE_CHASE  = 2'd3;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_PATTERN = 2'd1;
   localparam logic [1:0] ADDR_PERIOD  = 2'd2;
   localparam logic [1:0] ADDR_DUTY    = 2'd3;

   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(16);

   // Registers and their next-state values
   logic [1:0]          ctrl_q,    ctrl_d;
   logic [N_LEDS-1:0]   pattern_q, pattern_d;
   logic [PERIOD_W-1:0] period_q,  period_d;
   logic [DUTY_W-1:0]   duty_q,    duty_d;
   logic [PERIOD_W-1:0] presc_q,   presc_d;
   logic                phase_q,   phase_d;
   logic [N_LEDS-1:0]   frame_q,   frame_d;
   logic [PWM_W-1:0]    pwm_q,     pwm_d;
   logic [N_LEDS-1:0]   out_q,     out_d;

   logic                wr_en;
   logic                wr_ctrl;
   logic                wr_pattern;
   logic                wr_period;
   logic                wr_duty;
   logic                step_hit;
   logic                step_fire;
   logic                blink_phase;
   logic                pwm_gate;
   logic                seq_mode;
   logic [N_LEDS-1:0]   frame_rot;

   // Bus write decode
   assign wr_en      = chipselect & ~write_n;
   assign wr_ctrl    = wr_en && (address == ADDR_CTRL);
   assign wr_pattern = wr_en && (address == ADDR_PATTERN);
   assign wr_period  = wr_en && (address == ADDR_PERIOD);
   assign wr_duty    = wr_en && (address == ADDR_DUTY);

   // Step pulse; a bus write in the same cycle takes priority and drops it
   assign step_hit  = (presc_q == period_q);
   assign step_fire = step_hit && !wr_en && (ctrl_q != MODE_OFF);

   // Modes whose frame is derived from PATTERN over time
   assign seq_mode  = (ctrl_q == MODE_BLINK) || (ctrl_q == MODE_CHASE);

   // Rotate left by one, MSB wraps into bit 0
   assign frame_rot = (frame_q << 1) | (frame_q >> (N_LEDS - 1));

   // Brightness gate: pwm_cnt 0..15 compared against DUTY 0..16
   assign pwm_gate  = ({1'b0, pwm_q} < duty_q);

   // Register file next-state
   always_comb begin
      ctrl_d    = ctrl_q;
      pattern_d = pattern_q;
      period_d  = period_q;
      duty_d    = duty_q;

      if (wr_ctrl) begin
         ctrl_d = writedata[1:0];
      end
      if (wr_pattern) begin
         pattern_d = writedata[N_LEDS-1:0];
      end
      if (wr_period) begin
         period_d = writedata[PERIOD_W-1:0];
      end
      if (wr_duty) begin
         // Brightness saturates at full-on
         if (writedata > DATA_W'(DUTY_MAX)) begin
            duty_d = DUTY_MAX;
         end else begin
            duty_d = writedata[DUTY_W-1:0];
         end
      end
   end

   // Prescaler next-state
   always_comb begin
      presc_d = presc_q;

      if (ctrl_q == MODE_OFF) begin
         presc_d = '0;
      end else if (presc_q >= period_q) begin
         // Covers the normal terminal count and a PERIOD shrunk below the count
         presc_d = '0;
      end else begin
         presc_d = presc_q + PERIOD_W'(1);
      end

      if (wr_ctrl || (wr_pattern && seq_mode)) begin
         presc_d = '0;
      end
   end

   // Mode FSM next-state: frame and blink phase
   always_comb begin
      phase_d     = phase_q;
      frame_d     = frame_q;
      blink_phase = step_fire ? ~phase_q : phase_q;

      case (ctrl_q)
         MODE_OFF: begin
            frame_d = '0;
         end
         MODE_STATIC: begin
            frame_d = pattern_q;
         end
         MODE_BLINK: begin
            phase_d = blink_phase;
            frame_d = blink_phase ? pattern_q : '0;
         end
         MODE_CHASE: begin
            if (step_fire) begin
               frame_d = frame_rot;
            end
         end
         default: begin
            frame_d = '0;
         end
      endcase

      // New pattern restarts the running sequence from the current phase
      if (wr_pattern && seq_mode) begin
         if ((ctrl_q == MODE_BLINK) && !phase_q) begin
            frame_d = '0;
         end else begin
            frame_d = writedata[N_LEDS-1:0];
         end
      end

      // Mode entry, including re-entry into the same mode
      if (wr_ctrl) begin
         phase_d = 1'b1;
         if (writedata[1:0] == MODE_OFF) begin
            frame_d = '0;
         end else begin
            frame_d = pattern_q;
         end
      end
   end

   // PWM counter and gated LED output
   always_comb begin
      pwm_d = pwm_q + PWM_W'(1);
      out_d = frame_q & {N_LEDS{pwm_gate}};
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q    <= MODE_OFF;
         pattern_q <= '0;
         period_q  <= PERIOD_W'(PERIOD_RST);
         duty_q    <= DUTY_MAX;
         presc_q   <= '0;
         phase_q   <= 1'b1;
         frame_q   <= '0;
         pwm_q     <= '0;
         out_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         pattern_q <= pattern_d;
         period_q  <= period_d;
         duty_q    <= duty_d;
         presc_q   <= presc_d;
         phase_q   <= phase_d;
         frame_q   <= frame_d;
         pwm_q     <= pwm_d;
         out_q     <= out_d;
      end
   end

   assign out_port = out_q;

   // Zero-wait-state readback; address 3 also exposes the live frame
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:    readdata = DATA_W'(ctrl_q);
         ADDR_PATTERN: readdata = DATA_W'(pattern_q);
         ADDR_PERIOD:  readdata = DATA_W'(period_q);
         default: begin
            readdata[STEP_LSB +: N_LEDS] = frame_q;
            readdata[DUTY_W-1:0]         = duty_q;
         end
      endcase
   end

endmodule
